usb_frame_packer: RTL and testbench
===================================

Name: usb_frame_packer

Overview:
Upstream feeder for the FX2 slave-FIFO write path in the image capture system. Accepts an 8-bit pixel stream from the DDR3 read-back path and packs pixel pairs into 16-bit words. Prepends a 2-word frame header and pads each frame out to whole USB packets. Buffers the result in a FWFT FIFO that presents a valid/ready word stream with a per-packet end marker to the slave-FIFO writer (SLWR/PKTEND driver).

Parameters:
PKT_WORDS, 256, words per USB packet (512-byte bulk EP); power of 2
FIFO_DEPTH, 512, output FIFO depth in words; power of 2
SYNC_WORD, 16'hAA55, first header word of every frame
PAD_WORD, 16'h0000, filler word for packet padding

Ports:
FPGA_GCLK1  in  1  system clock; all logic on rising edge
CPU_RESET  in  1  synchronous, active-low reset
pix_data  in  8  pixel byte
pix_valid  in  1  pix_data valid
pix_sof  in  1  first pixel of frame, qualified by pix_valid
pix_eof  in  1  last pixel of frame, qualified by pix_valid
pix_ready  out  1  pixel accepted when pix_valid & pix_ready
tx_data  out  16  packed word to slave-FIFO writer
tx_valid  out  1  tx_data valid (FIFO not empty)
tx_ready  in  1  writer consumes word when tx_valid & tx_ready
tx_pkt_end  out  1  tx_data is last word of a packet
frame_cnt  out  16  count of completed frames, wraps at 16'hFFFF->0
frame_err  out  1  sticky: SOF seen before EOF; cleared only by reset

Behaviour:
- Reset (CPU_RESET=0 at clock edge): FSM->IDLE, FIFO emptied, pkt_idx=0, odd-byte latch cleared. Outputs: pix_ready=0, tx_valid=0, tx_data=0, tx_pkt_end=0, frame_cnt=0, frame_err=0. A reset mid-frame discards all buffered data.
- push_ok = FIFO count < FIFO_DEPTH. A pop in the same cycle does not enable a push.
- Every FIFO push stores {pkt_end, word}. pkt_end=1 when pkt_idx==PKT_WORDS-1. pkt_idx increments per push, wraps to 0, and resets to 0 at each frame start.
- FSM states:
  - IDLE: pix_ready=1. Non-SOF beats are accepted and discarded. On accepting an SOF beat, latch its byte and go to HDR0. An SOF+EOF beat is a 1-pixel frame.
  - HDR0: push SYNC_WORD when push_ok, then go to HDR1.
  - HDR1: push frame_cnt, then go to DATA, or to FLUSH if the SOF beat carried EOF.
  - DATA: pix_ready=push_ok. Packing order is first byte -> [7:0], second byte -> [15:8]. Push on the second byte. On EOF go to FLUSH.
  - Only the SOF byte latched in IDLE is consumed before HDR0. Packing resumes in DATA with that byte pending.
  - SOF during DATA: pix_ready=0 for that beat (pixel held upstream), set frame_err, go to FLUSH. The held pixel then starts the next frame through IDLE.
  - FLUSH: if an odd byte is pending, push {8'h00, byte}; then go to PAD.
  - PAD: if pkt_idx==0, go to DONE. Else push PAD_WORD each push_ok cycle until the pushed word carried pkt_end.
  - DONE: frame_cnt++ (one cycle), go to IDLE.
- Header/pad/flush pushes stall while FIFO is full; no data is ever dropped.
- Output FIFO is FWFT. tx_valid=!empty. tx_data/tx_pkt_end show the head entry. Pop on tx_valid & tx_ready. A push into an empty FIFO is visible on tx_valid the next cycle.
- tx_data/tx_pkt_end hold stable while tx_valid & !tx_ready.

Decomposition:
- Package usb_pkt_pkg: FSM state enum (IDLE, HDR0, HDR1, DATA, FLUSH, PAD, DONE); default SYNC_WORD/PAD_WORD constants; FIFO entry width constant (17).
- Sub-module usb_tx_fifo: synchronous FWFT FIFO, 17 bits x FIFO_DEPTH, exposes count/full/empty. Same clock/reset ports.

Test Plan:
- 4-pixel frame 01,02,03,04, tx_ready=1 -> words AA55,0000,0201,0403, then 252x 0000. tx_pkt_end only on word 256. frame_cnt=1.
- Odd 3-pixel frame 11,22,33 (second frame) -> AA55,0001,2211,0033, then 252x 0000. frame_cnt=2.
- 508-pixel frame (254 data words) -> exactly 256 words, no PAD words, tx_pkt_end on word 256.
- tx_ready=0, 1200-pixel frame -> 512 words buffered, pix_ready deasserts, FIFO stays full. Release tx_ready -> all 602+pad words delivered in order, no loss.
- SOF asserted at pixel 5 of a frame -> frame_err=1, 5th... actually pixels 1-4 packed, packet padded, next header AA55,0001, held pixel is first data byte.
- CPU_RESET=0 for 1 cycle mid-frame -> next cycle tx_valid=0, frame_cnt=0, frame_err=0. Following frame produces a clean header AA55,0000.

Source files
------------

// File: rtl/usb_pkt_pkg.sv
// Shared types and constants for the USB frame packer slice.
package usb_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    FLUSH,
    PAD,
    DONE
  } state_t;

  localparam logic [15:0] DEF_SYNC_WORD = 16'hAA55;
  localparam logic [15:0] DEF_PAD_WORD  = 16'h0000;

  // FIFO entry: {pkt_end, word[15:0]}
  localparam int unsigned ENTRY_W = 17;

endpackage

// File: rtl/usb_frame_packer_if.sv
// Pixel input stream and packed-word output stream of the frame packer.
interface usb_frame_packer_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_eof;
  logic        pix_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_pkt_end;

  // Packer side: sinks pixels, sources packed words.
  modport master (
    input  pix_data, pix_valid, pix_sof, pix_eof, tx_ready,
    output pix_ready, tx_data, tx_valid, tx_pkt_end
  );

  // Environment side: sources pixels, sinks packed words.
  modport slave (
    output pix_data, pix_valid, pix_sof, pix_eof, tx_ready,
    input  pix_ready, tx_data, tx_valid, tx_pkt_end
  );
endinterface

// File: rtl/usb_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the slave-FIFO writer.
module usb_tx_fifo
  import usb_pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                       FPGA_GCLK1,
  input  logic                       CPU_RESET,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head entry is shown directly; zero while empty so reset presents zeros.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge FPGA_GCLK1) begin
    if (!CPU_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge FPGA_GCLK1) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usb_frame_packer.sv
// Packs 8-bit pixels into 16-bit words, frames them with a header and
// pads each frame to whole USB packets, buffering through a FWFT FIFO.
module usb_frame_packer
  import usb_pkt_pkg::*;
#(
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [15:0] SYNC_WORD  = DEF_SYNC_WORD,
  parameter logic [15:0] PAD_WORD   = DEF_PAD_WORD
) (
  input  logic                FPGA_GCLK1,
  input  logic                CPU_RESET,
  usb_frame_packer_if.master  bus,
  output logic [15:0]         frame_cnt,
  output logic                frame_err
);

  localparam int unsigned PIDX_W = $clog2(PKT_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              state_n;
  logic [PIDX_W-1:0]   pkt_idx;
  logic                pkt_end;
  logic [7:0]          odd_byte;
  logic                odd_valid;
  logic                eof_flag;
  logic                push;
  logic [15:0]         push_word;
  logic                pix_rdy;
  logic                accept;
  logic                push_ok;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_dout;

  assign push_ok       = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign pkt_end       = (pkt_idx == PIDX_W'(PKT_WORDS - 1));
  assign bus.pix_ready = CPU_RESET && pix_rdy;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign bus.tx_valid  = !fifo_empty;
  assign bus.tx_data   = fifo_dout[15:0];
  assign bus.tx_pkt_end = fifo_dout[16];

  // State register.
  always_ff @(posedge FPGA_GCLK1) begin
    if (!CPU_RESET) state <= IDLE;
    else            state <= state_n;
  end

  // Next state, FIFO push request and pixel-ready decode.
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_word = '0;
    pix_rdy   = 1'b0;
    unique case (state)
      IDLE: begin
        pix_rdy = 1'b1;
        if (bus.pix_valid && bus.pix_sof) state_n = HDR0;
      end
      HDR0: begin
        if (push_ok) begin
          push      = 1'b1;
          push_word = SYNC_WORD;
          state_n   = HDR1;
        end
      end
      HDR1: begin
        if (push_ok) begin
          push      = 1'b1;
          push_word = frame_cnt;
          state_n   = eof_flag ? FLUSH : DATA;
        end
      end
      DATA: begin
        // An SOF here is refused so the pixel is replayed into the next frame.
        if (bus.pix_valid && bus.pix_sof) begin
          state_n = FLUSH;
        end else begin
          pix_rdy = push_ok;
          if (bus.pix_valid && push_ok) begin
            if (odd_valid) begin
              push      = 1'b1;
              push_word = {bus.pix_data, odd_byte};
            end
            if (bus.pix_eof) state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (odd_valid) begin
          if (push_ok) begin
            push      = 1'b1;
            push_word = {8'h00, odd_byte};
            state_n   = PAD;
          end
        end else begin
          state_n = PAD;
        end
      end
      PAD: begin
        if (pkt_idx == '0) begin
          state_n = DONE;
        end else if (push_ok) begin
          push      = 1'b1;
          push_word = PAD_WORD;
          if (pkt_end) state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: odd-byte latch, packet index, frame counter and error flag.
  always_ff @(posedge FPGA_GCLK1) begin
    if (!CPU_RESET) begin
      odd_byte  <= '0;
      odd_valid <= 1'b0;
      eof_flag  <= 1'b0;
      pkt_idx   <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (state == IDLE && accept && bus.pix_sof) begin
        odd_byte  <= bus.pix_data;
        odd_valid <= 1'b1;
        eof_flag  <= bus.pix_eof;
        pkt_idx   <= '0;
      end else if (push) begin
        pkt_idx <= pkt_idx + 1'b1;
      end

      if (state == DATA && accept) begin
        if (odd_valid) begin
          odd_valid <= 1'b0;
        end else begin
          odd_byte  <= bus.pix_data;
          odd_valid <= 1'b1;
        end
      end

      if (state == FLUSH && push) odd_valid <= 1'b0;

      if (state == DATA && bus.pix_valid && bus.pix_sof) frame_err <= 1'b1;

      if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Count and full flag describe the same occupancy.
  always_ff @(posedge FPGA_GCLK1) begin
    if (CPU_RESET) assert (fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));
  end

  usb_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .FPGA_GCLK1 (FPGA_GCLK1),
    .CPU_RESET  (CPU_RESET),
    .push       (push),
    .din        ({pkt_end, push_word}),
    .pop        (bus.tx_valid && bus.tx_ready),
    .dout       (fifo_dout),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_usb_frame_packer.sv
// Scoreboard bench for usb_frame_packer: expected words are queued when a
// frame is issued; a monitor pops and compares on every accepted tx word.
module tb_usb_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_cnt;
  logic        frame_err;

  always #5 clk = ~clk;

  usb_frame_packer_if bus ();

  usb_frame_packer #(
    .PKT_WORDS  (256),
    .FIFO_DEPTH (512)
  ) dut (
    .FPGA_GCLK1 (clk),
    .CPU_RESET  (rst_n),
    .bus        (bus),
    .frame_cnt  (frame_cnt),
    .frame_err  (frame_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  logic [16:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [7:0]  px[$];
  logic        drv_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream of one frame: header, packed pairs, odd tail, packet padding.
  task automatic model_frame(input logic [7:0] p[$]);
    logic [15:0] w[$];
    int n;
    n = p.size();
    w.push_back(16'hAA55);
    w.push_back(exp_cnt);
    for (int i = 0; i + 1 < n; i += 2) w.push_back({p[i+1], p[i]});
    if (n % 2 == 1) w.push_back({8'h00, p[n-1]});
    while (w.size() % 256 != 0) w.push_back(16'h0000);
    for (int i = 0; i < w.size(); i++) exp_q.push_back({(i % 256) == 255, w[i]});
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eof);
    int  n;
    logic rdy;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    bus.pix_eof   = eof;
    bus.pix_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 5000);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL pix_accept_timeout: got not-ready expected ready (byte %h)", d);
    end
  endtask

  task automatic drive_frame(input logic [7:0] p[$]);
    for (int i = 0; i < p.size(); i++) send(p[i], i == 0, i == p.size() - 1);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted output word against the scoreboard.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e[15:0]));
          check("tx_pkt_end", 32'(bus.tx_pkt_end), 32'(e[16]));
        end
        popped++;
      end
    end
  end

  initial begin
    int base;
    bus.pix_data  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_eof   = 1'b0;
    bus.tx_ready  = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_pkt_end", 32'(bus.tx_pkt_end), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Even 4-pixel frame: AA55,0000,0201,0403 + 252 pad.
    px = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_frame(px);
    base = popped;
    drive_frame(px);
    wait_drain();
    check("f1_words", 32'(popped - base), 32'd256);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Odd 3-pixel frame: AA55,0001,2211,0033 + 252 pad.
    px = '{8'h11, 8'h22, 8'h33};
    model_frame(px);
    drive_frame(px);
    wait_drain();
    check("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // 508 pixels fill exactly one packet, no padding.
    px.delete();
    for (int i = 0; i < 508; i++) px.push_back(8'(i + 3));
    model_frame(px);
    base = popped;
    drive_frame(px);
    wait_drain();
    check("f3_words", 32'(popped - base), 32'd256);
    check("f3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Single-pixel frame (SOF+EOF on one beat).
    px = '{8'h5A};
    model_frame(px);
    drive_frame(px);
    wait_drain();
    check("f4_frame_cnt", 32'(frame_cnt), 32'd4);

    // Backpressure: 1200 pixels with tx_ready low fill the FIFO.
    bus.tx_ready = 1'b0;
    px.delete();
    for (int i = 0; i < 1200; i++) px.push_back(8'(i * 7));
    model_frame(px);
    base = popped;
    drv_done = 1'b0;
    fork
      begin
        drive_frame(px);
        drv_done = 1'b1;
      end
    join_none
    repeat (1500) @(posedge clk);
    @(negedge clk);
    check("full_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("full_tx_valid", 32'(bus.tx_valid), 32'd1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("full_hold_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("full_no_pop", 32'(popped - base), 32'd0);
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    for (int n = 0; n < 20000 && !drv_done; n++) @(posedge clk);
    check("big_driver_done", 32'(drv_done), 32'd1);
    wait_drain();
    check("big_words", 32'(popped - base), 32'd768);
    check("big_frame_cnt", 32'(frame_cnt), 32'd5);

    // SOF on pixel 5: frame closes after 4 pixels, held pixel opens next frame.
    px = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    model_frame(px);
    px = '{8'hB5, 8'hB6, 8'hB7, 8'hB8};
    model_frame(px);
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b0);
    send(8'hA4, 1'b0, 1'b0);
    send(8'hB5, 1'b1, 1'b0);
    send(8'hB6, 1'b0, 1'b0);
    send(8'hB7, 1'b0, 1'b0);
    send(8'hB8, 1'b0, 1'b1);
    bus.pix_valid = 1'b0;
    wait_drain();
    check("err_frame_err", 32'(frame_err), 32'd1);
    check("err_frame_cnt", 32'(frame_cnt), 32'd7);

    // Reset mid-frame discards buffered words and clears counters.
    bus.tx_ready = 1'b0;
    send(8'hC1, 1'b1, 1'b0);
    send(8'hC2, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    bus.pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    exp_cnt = '0;
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    px = '{8'hD1, 8'hD2};
    model_frame(px);
    drive_frame(px);
    wait_drain();
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
